// File: rtl/ftsd_scan_capture.sv
// Receive side of the 14-segment scan bus: synchronises select/data, captures each
// stably-held digit into its own register and flags frame completion and scan errors.
module ftsd_scan_capture #(
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CNT  = 4,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] ftsd_ctl,
    input  logic [5:0] ftsd_in,
    input  logic       clr_valid,
    output logic [5:0] out0,
    output logic [5:0] out1,
    output logic [5:0] out2,
    output logic [5:0] out3,
    output logic [3:0] digit_valid,
    output logic       frame_done,
    output logic       seq_err,
    output logic       sel_err
);
    logic [SYNC_STAGES-1:0][3:0] r_ctl_sync;
    logic [SYNC_STAGES-1:0][5:0] r_dat_sync;
    logic [3:0]       r_prev_ctl;
    logic [5:0]       r_prev_dat;
    logic [CNT_W-1:0] r_cnt;
    logic             r_captured;
    logic [1:0]       r_expect;
    logic [3:0][5:0]  r_out;
    logic [3:0]       r_valid;
    logic             r_frame_done;
    logic             r_seq_err;
    logic             r_sel_err;

    logic [3:0]       w_sctl;
    logic [5:0]       w_sdat;
    logic             w_legal;
    logic             w_illegal;
    logic [1:0]       w_idx;
    logic             w_changed;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_capture;

    assign w_sctl = r_ctl_sync[SYNC_STAGES-1];
    assign w_sdat = r_dat_sync[SYNC_STAGES-1];

    always_comb begin
        w_legal = 1'b1;
        w_idx   = 2'd0;
        case (w_sctl)
            4'b0111: w_idx = 2'd0;
            4'b1011: w_idx = 2'd1;
            4'b1101: w_idx = 2'd2;
            4'b1110: w_idx = 2'd3;
            default: w_legal = 1'b0;
        endcase
    end

    assign w_illegal = !w_legal && (w_sctl != 4'b1111);
    assign w_changed = {w_sctl, w_sdat} != {r_prev_ctl, r_prev_dat};

    // Counter value for this edge; capturing on it keeps latency at SYNC_STAGES+STABLE_CNT.
    assign w_cnt_next = w_changed ? CNT_W'(1) :
                        (r_cnt == CNT_W'(STABLE_CNT)) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_capture  = w_legal && (w_cnt_next == CNT_W'(STABLE_CNT)) &&
                        (w_changed || !r_captured);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_ctl_sync[i] <= 4'b1111;
                r_dat_sync[i] <= 6'd0;
            end
            r_prev_ctl <= 4'b1111;
            r_prev_dat <= 6'd0;
            r_cnt      <= '0;
            r_captured <= 1'b0;
        end else begin
            r_ctl_sync[0] <= ftsd_ctl;
            r_dat_sync[0] <= ftsd_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_ctl_sync[i] <= r_ctl_sync[i-1];
                r_dat_sync[i] <= r_dat_sync[i-1];
            end
            r_prev_ctl <= w_sctl;
            r_prev_dat <= w_sdat;
            r_cnt      <= w_cnt_next;
            r_captured <= w_capture || (!w_changed && r_captured);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out        <= '0;
            r_valid      <= 4'd0;
            r_expect     <= 2'd0;
            r_frame_done <= 1'b0;
            r_seq_err    <= 1'b0;
            r_sel_err    <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_seq_err    <= 1'b0;
            r_sel_err    <= w_illegal && (w_sctl != r_prev_ctl);
            if (clr_valid) begin
                r_valid  <= 4'd0;
                r_expect <= 2'd0;
            end
            // Capture overrides a coincident clear for its own digit and the tracker.
            if (w_capture) begin
                r_out[w_idx] <= w_sdat;
                if (clr_valid)
                    r_valid <= 4'b0001 << w_idx;
                else
                    r_valid[w_idx] <= 1'b1;
                if (w_idx == r_expect) begin
                    r_expect     <= r_expect + 2'd1;
                    r_frame_done <= (w_idx == 2'd3);
                end else begin
                    r_seq_err <= 1'b1;
                    r_expect  <= (w_idx == 2'd0) ? 2'd1 : 2'd0;
                end
            end
        end
    end

    assign out0        = r_out[0];
    assign out1        = r_out[1];
    assign out2        = r_out[2];
    assign out3        = r_out[3];
    assign digit_valid = r_valid;
    assign frame_done  = r_frame_done;
    assign seq_err     = r_seq_err;
    assign sel_err     = r_sel_err;
endmodule

// File: tb/tb_ftsd_scan_capture.sv
// Directed bench for ftsd_scan_capture: default instance plus a STABLE_CNT=6 instance
// used only for the short-dwell case.
module tb_ftsd_scan_capture;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] ftsd_ctl;
    logic [5:0] ftsd_in;
    logic       clr_valid;
    logic [5:0] out0, out1, out2, out3;
    logic [3:0] digit_valid;
    logic       frame_done, seq_err, sel_err;
    logic [5:0] s_out0, s_out1, s_out2, s_out3;
    logic [3:0] s_valid;
    logic       s_frame, s_seq, s_sel;

    int tests = 0;
    int fails = 0;
    int n_frame = 0, n_seq = 0, n_sel = 0;

    always #5 clk = ~clk;

    ftsd_scan_capture dut (
        .clk(clk), .rst_n(rst_n), .ftsd_ctl(ftsd_ctl), .ftsd_in(ftsd_in),
        .clr_valid(clr_valid), .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .digit_valid(digit_valid), .frame_done(frame_done), .seq_err(seq_err),
        .sel_err(sel_err)
    );

    ftsd_scan_capture #(.STABLE_CNT(6)) dut_short (
        .clk(clk), .rst_n(rst_n), .ftsd_ctl(ftsd_ctl), .ftsd_in(ftsd_in),
        .clr_valid(clr_valid), .out0(s_out0), .out1(s_out1), .out2(s_out2), .out3(s_out3),
        .digit_valid(s_valid), .frame_done(s_frame), .seq_err(s_seq), .sel_err(s_sel)
    );

    always @(negedge clk) begin
        if (frame_done) n_frame++;
        if (seq_err)    n_seq++;
        if (sel_err)    n_sel++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [3:0] c, input logic [5:0] d);
        ftsd_ctl = c;
        ftsd_in  = d;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_cnt();
        n_frame = 0;
        n_seq   = 0;
        n_sel   = 0;
    endtask

    task automatic scan(input logic [5:0] d0, input logic [5:0] d1,
                        input logic [5:0] d2, input logic [5:0] d3);
        apply(4'b0111, d0); step(8);
        apply(4'b1011, d1); step(8);
        apply(4'b1101, d2); step(8);
        apply(4'b1110, d3); step(8);
        apply(4'b1111, 6'h00); step(8);
    endtask

    initial begin
        rst_n = 1'b0; clr_valid = 1'b0;
        apply(4'b1111, 6'h00);
        step(3);
        chk("rst_outs", {out0, out1, out2, out3}, 24'h0);
        chk("rst_valid", digit_valid, 4'h0);
        chk("rst_pulses", {frame_done, seq_err, sel_err}, 3'b000);
        rst_n = 1'b1;

        // Short dwell against the STABLE_CNT=6 instance
        apply(4'b0111, 6'h05); step(5);
        apply(4'b1011, 6'h0A); step(5);
        apply(4'b1101, 6'h15); step(5);
        apply(4'b1110, 6'h3F); step(5);
        apply(4'b1111, 6'h00); step(10);
        chk("short_valid", s_valid, 4'h0);
        chk("short_out0", s_out0, 6'h00);

        // Normal scan
        rst_n = 1'b0; step(2); rst_n = 1'b1;
        clr_cnt();
        apply(4'b0111, 6'h05); step(8);
        apply(4'b1011, 6'h0A); step(8);
        apply(4'b1101, 6'h15); step(8);
        apply(4'b1110, 6'h3F); step(5);
        chk("frame_early", frame_done, 1'b0);
        step(1);
        chk("frame_pulse", frame_done, 1'b1);
        step(1);
        chk("frame_clear", frame_done, 1'b0);
        step(1);
        chk("scan_outs", {out0, out1, out2, out3}, {6'h05, 6'h0A, 6'h15, 6'h3F});
        chk("scan_valid", digit_valid, 4'hF);
        chk("scan_seq", n_seq, 0);
        chk("scan_frames", n_frame, 1);
        apply(4'b1111, 6'h00); step(8);

        // Data change inside a long dwell
        apply(4'b0111, 6'h01); step(5);
        chk("dc_before", out0, 6'h05);
        step(1);
        chk("dc_first", out0, 6'h01);
        step(4);
        apply(4'b0111, 6'h02); step(5);
        chk("dc_noseq", seq_err, 1'b0);
        step(1);
        chk("dc_second", out0, 6'h02);
        chk("dc_seq", seq_err, 1'b1);
        step(1);
        chk("dc_seq_1cyc", seq_err, 1'b0);
        step(3);
        apply(4'b1111, 6'h00); step(8);

        // Order violation, then a clean frame
        clr_valid = 1'b1; step(1); clr_valid = 1'b0;
        chk("clr_valid", digit_valid, 4'h0);
        clr_cnt();
        apply(4'b0111, 6'h11); step(8);
        apply(4'b1011, 6'h12); step(8);
        apply(4'b1110, 6'h13); step(8);
        apply(4'b1111, 6'h00); step(8);
        chk("ord_seq", n_seq, 1);
        chk("ord_noframe", n_frame, 0);
        chk("ord_valid", digit_valid, 4'b1011);
        scan(6'h05, 6'h0A, 6'h15, 6'h3F);
        chk("ord_frame", n_frame, 1);
        chk("ord_seq_after", n_seq, 1);

        // Illegal and idle select patterns
        clr_cnt();
        apply(4'b0000, 6'h00); step(10);
        chk("sel_0000", n_sel, 1);
        apply(4'b1111, 6'h00); step(10);
        chk("sel_idle", n_sel, 1);
        apply(4'b0011, 6'h2A); step(10);
        chk("sel_0011", n_sel, 2);
        apply(4'b1111, 6'h00); step(8);
        chk("sel_outs", {out0, out1, out2, out3}, {6'h05, 6'h0A, 6'h15, 6'h3F});
        chk("sel_valid", digit_valid, 4'hF);
        chk("sel_nocap", n_seq + n_frame, 0);

        // Reset mid-dwell, then clear coincident with a capture
        apply(4'b0111, 6'h07); step(4);
        rst_n = 1'b0; step(1);
        chk("mid_rst_outs", {out0, out1, out2, out3}, 24'h0);
        chk("mid_rst_valid", digit_valid, 4'h0);
        rst_n = 1'b1;
        step(5);
        chk("mid_rst_early", out0, 6'h00);
        step(1);
        chk("mid_rst_cap", out0, 6'h07);
        chk("mid_rst_valid1", digit_valid, 4'b0001);
        step(2);
        apply(4'b1011, 6'h09); step(5);
        clr_valid = 1'b1; step(1); clr_valid = 1'b0;
        chk("clrcap_valid", digit_valid, 4'b0010);
        chk("clrcap_out1", out1, 6'h09);
        chk("clrcap_out0", out0, 6'h07);
        chk("clrcap_seq", seq_err, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ftsd_scan_capture.md
Name: ftsd_scan_capture

Overview:
- Receive-side counterpart of the 14-segment scan multiplexer.
- Monitors the multiplexed display bus, which carries a 4-bit active-low digit select plus 6-bit digit data.
- Captures each scanned digit into its own register, flags digit validity, and reports frame completion, scan-order errors and illegal select patterns.
- Used on the receiving board of a board-to-board display link and as a bus monitor in system benches.

Parameters:
- SYNC_STAGES, 2, number of input synchroniser flops on ftsd_ctl/ftsd_in; legal range 1..3.
- STABLE_CNT, 4, consecutive synchronised cycles a (select, data) pair must hold unchanged before capture; legal range 1..255.
- CNT_W, 8, width of the stability counter; must hold STABLE_CNT.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous reset, active low.
- ftsd_ctl  input  4  scanned digit select, active low (0111=digit0, 1011=digit1, 1101=digit2, 1110=digit3, 1111=idle).
- ftsd_in  input  6  scanned digit data.
- out0..out3  output  6 each  captured data for digits 0..3.
- digit_valid  output  4  bit i set once digit i has been captured since reset or since the last clear.
- clr_valid  input  1  synchronous clear of digit_valid and of the sequence tracker; out0..out3 are retained.
- frame_done  output  1  one-cycle pulse when digits 0,1,2,3 have been captured in order.
- seq_err  output  1  one-cycle pulse on an out-of-order capture.
- sel_err  output  1  one-cycle pulse on entry into an illegal select pattern.

Behaviour:
- Reset is synchronous and active low. The design has one clock (clk), and every register updates only on the rising edge of clk.
- Reset values:
  - out0..out3=0, digit_valid=0, frame_done=0, seq_err=0, sel_err=0.
  - Synchroniser ctl flops=4'b1111 and data flops=0, so the post-reset bus reads as idle.
  - Stability counter=0, captured flag=0, expected index=0.
- Synchroniser: ftsd_ctl and ftsd_in each pass through SYNC_STAGES flops. All logic below uses the synchronised values (sctl, sdat).
- Pattern classes:
  - Legal: 0111, 1011, 1101, 1110, mapping to index 0..3.
  - Idle: 1111.
  - Anything else is illegal, including 0000.
- Stability counter:
  - If (sctl,sdat) differs from its value in the previous cycle, the counter loads 1 and the captured flag clears.
  - Otherwise the counter increments, saturating at STABLE_CNT.
- Capture:
  - Occurs in the cycle the counter equals STABLE_CNT while sctl is legal and the captured flag is 0.
  - On that edge: out[index]<=sdat, digit_valid[index]<=1, captured flag<=1.
  - Exactly one capture per stable dwell.
  - A data change inside a long dwell restarts the counter and produces a fresh capture once the new data is stable.
- Latency: from an input change that is then held, the outX update is visible SYNC_STAGES+STABLE_CNT cycles later (6 cycles with defaults).
- Idle and illegal patterns:
  - Never capture; they leave out* and digit_valid unchanged.
  - sel_err pulses for one cycle on the first cycle sctl enters an illegal pattern from any other value. Holding the illegal pattern produces no further pulses.
- Sequence tracker:
  - A 2-bit expected index starts at 0.
  - On a capture with index==expected: expected<=expected+1, wrapping 3->0. If index==3, frame_done pulses on the same edge as the capture.
  - On a capture with index!=expected: seq_err pulses and no frame_done is issued.
    - If index==0, expected<=1, so the frame restarts.
    - Otherwise expected<=0.
  - Repeated capture of the same digit after a data change counts as a capture and is checked the same way.
- clr_valid: clears digit_valid and expected on the next edge. If clr_valid and a capture coincide, the capture wins for out*, digit_valid[index] and the tracker.
- Reset mid-dwell discards the partial count. After reset, a held legal pattern takes a full SYNC_STAGES+STABLE_CNT cycles to capture.
- Pulse outputs are registered: frame_done, seq_err and sel_err are never high for two consecutive cycles due to a single event.

Test Plan:
- Reset then normal scan: cycle 0111/0x05, 1011/0x0A, 1101/0x15, 1110/0x3F with 8-cycle dwells. Required: out0..3=05,0A,15,3F; digit_valid=1111; frame_done pulses once per frame, 6 cycles after 1110 is applied; seq_err=0.
- Short dwell: hold each pattern 5 cycles with STABLE_CNT=6. Required: no capture and digit_valid stays 0000.
- Data change inside dwell: ctl=0111 for 20 cycles, data 0x01 switching to 0x02 at cycle 10. Required: out0=01 at cycle 6, then out0=02 at cycle 16; seq_err pulses at cycle 16 because expected is now 1.
- Order violation: scan 0, 1, 3. Required: seq_err pulses on the digit-3 capture, no frame_done. Then scanning 0,1,2,3 yields frame_done.
- Illegal and idle: apply 0000 for 10 cycles, then 1111, then 0011. Required: sel_err pulses once for 0000 and once for 0011, none for 1111; outputs unchanged.
- Reset mid-dwell and clr_valid: drop rst_n for 1 cycle at dwell cycle 4 of digit0. Required: all outputs 0 and capture 6 cycles after release. Then clr_valid coincident with a digit1 capture leaves digit_valid=0010.
